// File: rtl/s_array_reader_pkg.sv
// rc4_pkg: constants and types shared by the RC4 S-array blocks
// (initializer, KSA and this reader).
//   ADDR_W         - address width of the S-array RAM
//   DATA_W         - data width of the S-array RAM
//   S_DEPTH        - number of entries in S
//   reader_state_t - state encoding of the S-array reader
package rc4_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int S_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/s_array_reader_if.sv
// s_array_reader_if: bundles the RAM read port and the output byte stream
// of the S-array reader.
//   address   - RAM address (reader -> RAM)
//   wren      - RAM write enable, always 0 from the reader
//   q         - RAM read data, one cycle after address (RAM -> reader)
//   out_data  - stream byte (reader -> consumer)
//   out_valid - out_data is valid (reader -> consumer)
//   out_ready - consumer accepts (consumer -> reader)
// master: the reader side.  slave: the RAM + consumer side.
interface s_array_reader_if #(
  parameter int ADDR_W = rc4_pkg::ADDR_W,
  parameter int DATA_W = rc4_pkg::DATA_W
);

  logic [ADDR_W-1:0] address;
  logic              wren;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output address, wren, out_data, out_valid,
    input  q, out_ready
  );

  modport slave (
    input  address, wren, out_data, out_valid,
    output q, out_ready
  );

endinterface

// File: rtl/s_array_reader_fifo.sv
// byte_fifo: small synchronous FIFO with a combinational head.
//   clk, rst_n - clock, asynchronous active-low reset
//   push/wdata - write one entry (ignored when full)
//   pop        - drop the head entry (ignored when empty)
//   rdata      - head entry; all storage resets to zero so rdata is 0
//                out of reset
//   full/empty - occupancy flags
//   count      - number of stored entries (0..DEPTH)
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_L);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/s_array_reader.sv
// s_array_reader: streams the RC4 state array S out of the single-port
// RAM in address order 0..255 over a valid/ready handshake, while
// computing an XOR checksum and checking that S is the identity.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a dump (only honoured in IDLE or DONE)
//   bus         - RAM read port + output stream (master side)
//   busy        - dump in progress (READ or DRAIN)
//   done        - level, last byte has transferred; cleared by start
//   checksum    - XOR of all transferred bytes
//   identity_ok - no transferred byte differed from its index
module s_array_reader #(
  parameter int ADDR_W     = rc4_pkg::ADDR_W,
  parameter int DATA_W     = rc4_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  s_array_reader_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    checksum,
  output logic                 identity_ok
);

  import rc4_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LAST_ADDR  = {1'b0, {ADDR_W{1'b1}}};

  reader_state_t     state_q, state_d;
  // Address currently on the RAM port; it only advances on an issue, so
  // under backpressure it parks on the last address actually read.
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic              rd_q, rd_d;      // address this cycle is a live read
  logic              cap_q;           // q this cycle carries a live read
  logic [ADDR_W-1:0] idx_q, idx_d;    // index of the next byte to transfer
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              ident_q, ident_d;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop;
  logic [CW:0]       credit_used;
  logic              credit_ok;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_q),
    .wdata (bus.q),
    .pop   (pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop = !fifo_empty && bus.out_ready;

  // Every read that is on the address port or returning on q will land in
  // the FIFO, so both count against the free entries. A pop in this cycle
  // is not credited; that keeps the data path free of any stall.
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(rd_q) + (CW+1)'(cap_q);
  assign credit_ok   = (credit_used < CREDIT_MAX) && !fifo_full;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rd_d        = 1'b0;
    idx_d       = idx_q;
    checksum_d  = checksum_q;
    ident_d     = ident_q;

    if (pop) begin
      checksum_d = checksum_q ^ fifo_dout;
      idx_d      = idx_q + 1'b1;
      if (fifo_dout != DATA_W'(idx_q)) begin
        ident_d = 1'b0;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Address 0 goes out in the first READ cycle.
          state_d     = READ;
          issue_cnt_d = '0;
          rd_d        = 1'b1;
          idx_d       = '0;
          checksum_d  = '0;
          ident_d     = 1'b1;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          rd_d        = 1'b1;
          if ((issue_cnt_q + 1'b1) == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (idx_q == '1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      rd_q        <= 1'b0;
      cap_q       <= 1'b0;
      idx_q       <= '0;
      checksum_q  <= '0;
      ident_q     <= 1'b1;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      rd_q        <= rd_d;
      cap_q       <= rd_q;
      idx_q       <= idx_d;
      checksum_q  <= checksum_d;
      ident_q     <= ident_d;
    end
  end

  assign bus.address   = issue_cnt_q[ADDR_W-1:0];
  assign bus.wren      = 1'b0;
  assign bus.out_data  = fifo_dout;
  assign bus.out_valid = !fifo_empty;
  assign busy          = (state_q == READ) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign checksum      = checksum_q;
  assign identity_ok   = ident_q;

endmodule

// File: tb/tb_s_array_reader.sv
// tb_s_array_reader: directed bench for s_array_reader. A RAM model answers
// reads one cycle after the address; a monitor logs every transfer with its
// cycle number relative to the start edge (cycle 1 follows that edge).
module tb_s_array_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic       identity_ok;

  logic [7:0] ram [256];
  logic [7:0] ram_q;
  int         edge_n     = 0;
  int         start_edge = 0;
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         done_cyc;
  logic [7:0] got_data [$];
  int         got_cyc  [$];

  s_array_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  s_array_reader #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .identity_ok (identity_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk) ram_q <= ram[bus.address];
  assign bus.q = ram_q;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_data.push_back(bus.out_data);
      got_cyc.push_back(edge_n - start_edge + 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled at edge 0; returns inside cycle 1.
  task automatic pulse_start();
    got_data.delete();
    got_cyc.delete();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    start_edge = edge_n;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 3000 && done !== 1'b1; c++) step();
    done_cyc = edge_n - start_edge + 1;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int patch_idx, input logic [7:0] patch_val);
    int bad = 0;
    check({tag, "_count"}, 32'(got_data.size()), 32'd256);
    for (int i = 0; i < got_data.size() && i < 256; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == patch_idx) ? patch_val : i[7:0];
      if (got_data[i] !== exp_b) bad++;
    end
    check({tag, "_order_errors"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"},  32'(bus.address),   32'h0);
    check({tag, "_wren"},     32'(bus.wren),      32'h0);
    check({tag, "_out_data"}, 32'(bus.out_data),  32'h0);
    check({tag, "_valid"},    32'(bus.out_valid), 32'h0);
    check({tag, "_busy"},     32'(busy),          32'h0);
    check({tag, "_done"},     32'(done),          32'h0);
    check({tag, "_checksum"}, 32'(checksum),      32'h0);
    check({tag, "_ident"},    32'(identity_ok),   32'h1);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i[7:0]] = i[7:0];

    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // 1: identity RAM, ready always high
    bus.out_ready = 1'b1;
    pulse_start();
    check("t1_c1_busy",  32'(busy),          32'h1);
    check("t1_c1_addr",  32'(bus.address),   32'h0);
    check("t1_c1_valid", 32'(bus.out_valid), 32'h0);
    step();
    check("t1_c2_addr",  32'(bus.address),   32'h1);
    check("t1_c2_valid", 32'(bus.out_valid), 32'h0);
    step();
    check("t1_c3_valid", 32'(bus.out_valid), 32'h1);
    check("t1_c3_data",  32'(bus.out_data),  32'h0);
    wait_done("t1");
    check("t1_done_cycle", 32'(done_cyc), 32'd259);
    check_stream("t1", -1, 8'h00);
    check("t1_first_cycle", 32'(got_cyc.size() > 0 ? got_cyc[0] : 0), 32'd3);
    check("t1_last_cycle",  32'(got_cyc.size() > 255 ? got_cyc[255] : 0), 32'd258);
    check("t1_checksum", 32'(checksum),    32'h00);
    check("t1_ident",    32'(identity_ok), 32'h1);
    check("t1_busy_end", 32'(busy),        32'h0);

    // 2: restart from DONE with pseudo-random ready
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'h0);
    check("t2_busy",         32'(busy), 32'h1);
    for (int c = 0; c < 3000 && done !== 1'b1; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_ready = 1'b1;
    wait_done("t2");
    check_stream("t2", -1, 8'h00);
    check("t2_checksum", 32'(checksum),    32'h00);
    check("t2_ident",    32'(identity_ok), 32'h1);

    // 3: S[0x10] = 0xAA
    ram[8'h10] = 8'hAA;
    pulse_start();
    repeat (18) step();
    check("t3_c19_valid", 32'(bus.out_valid), 32'h1);
    check("t3_c19_data",  32'(bus.out_data),  32'hAA);
    check("t3_c19_ident", 32'(identity_ok),   32'h1);
    step();
    check("t3_c20_ident", 32'(identity_ok),   32'h0);
    wait_done("t3");
    check_stream("t3", 16, 8'hAA);
    check("t3_checksum", 32'(checksum),    32'hBA);
    check("t3_ident",    32'(identity_ok), 32'h0);
    ram[8'h10] = 8'h10;

    // 4: ready low for cycles 1..20
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (4) step();
    check("t4_c5_addr", 32'(bus.address), 32'h3);
    repeat (15) step();
    check("t4_c20_addr",  32'(bus.address),     32'h3);
    check("t4_c20_valid", 32'(bus.out_valid),   32'h1);
    check("t4_c20_data",  32'(bus.out_data),    32'h0);
    check("t4_c20_xfers", 32'(got_data.size()), 32'd0);
    step();
    bus.out_ready = 1'b1;
    wait_done("t4");
    check_stream("t4", -1, 8'h00);
    check("t4_first_cycle", 32'(got_cyc.size() > 0 ? got_cyc[0] : 0), 32'd21);
    check("t4_checksum", 32'(checksum),    32'h00);
    check("t4_ident",    32'(identity_ok), 32'h1);

    // 5: reset after byte 100 transfers
    pulse_start();
    for (int c = 0; c < 400 && got_data.size() < 101; c++) step();
    check("t5_reached_100", 32'(got_data.size()), 32'd101);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    step();
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    wait_done("t5");
    check_stream("t5", -1, 8'h00);
    check("t5_checksum", 32'(checksum), 32'h00);

    // 6: start during READ at byte 50 is ignored
    pulse_start();
    for (int c = 0; c < 400 && got_data.size() < 50; c++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_busy_kept", 32'(busy), 32'h1);
    wait_done("t6");
    check("t6_done_cycle", 32'(done_cyc), 32'd259);
    check_stream("t6", -1, 8'h00);
    check("t6_checksum", 32'(checksum),    32'h00);
    check("t6_ident",    32'(identity_ok), 32'h1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
